// File: rtl/traffic_light_ctrl.sv
// -----------------------------------------------------------------------------
// traffic_light_ctrl
//
// Two-road (NS/EW) intersection controller. Cycles green -> yellow -> all-red
// for each direction, with phase durations counted in timebase ticks. A green
// phase that has run its minimum time is held until the crossing direction has
// a pending request. A maintenance request overrides everything and flashes
// yellow on both roads.
//
// Parameters:
//   CNT_W        width of the phase timer
//   GREEN_TICKS  minimum green duration in ticks (1..2^CNT_W)
//   YELLOW_TICKS yellow duration in ticks (1..2^CNT_W)
//   ALLRED_TICKS all-red clearance duration in ticks (1..2^CNT_W)
//
// Ports:
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   tick      one-cycle timebase strobe; timers only move on tick cycles
//   ns_req    NS demand (level or pulse), latched until NS green is entered
//   ew_req    EW demand (level or pulse), latched until EW green is entered
//   flash_en  maintenance flashing-yellow request
//   ns_lamp   NS lamps {red,yellow,green}, registered
//   ew_lamp   EW lamps {red,yellow,green}, registered
//   phase     current state encoding, for debug
// -----------------------------------------------------------------------------
module traffic_light_ctrl #(
    parameter int CNT_W        = 8,
    parameter int GREEN_TICKS  = 8,
    parameter int YELLOW_TICKS = 3,
    parameter int ALLRED_TICKS = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       ns_req,
    input  logic       ew_req,
    input  logic       flash_en,
    output logic [2:0] ns_lamp,
    output logic [2:0] ew_lamp,
    output logic [2:0] phase
);

    localparam logic [2:0] NS_G  = 3'd0;
    localparam logic [2:0] NS_Y  = 3'd1;
    localparam logic [2:0] RED_A = 3'd2;
    localparam logic [2:0] EW_G  = 3'd3;
    localparam logic [2:0] EW_Y  = 3'd4;
    localparam logic [2:0] RED_B = 3'd5;
    localparam logic [2:0] FLASH = 3'd6;

    localparam logic [2:0] LAMP_R    = 3'b100;
    localparam logic [2:0] LAMP_Y    = 3'b010;
    localparam logic [2:0] LAMP_G    = 3'b001;
    localparam logic [2:0] LAMP_DARK = 3'b000;

    // Timer load values: a phase of DUR ticks starts at DUR-1 and expires on
    // the tick that finds the timer at zero.
    localparam logic [CNT_W-1:0] GREEN_LOAD  = CNT_W'(GREEN_TICKS - 1);
    localparam logic [CNT_W-1:0] YELLOW_LOAD = CNT_W'(YELLOW_TICKS - 1);
    localparam logic [CNT_W-1:0] ALLRED_LOAD = CNT_W'(ALLRED_TICKS - 1);

    logic [2:0]       state, state_nxt;
    logic [CNT_W-1:0] timer, timer_nxt;
    logic             ns_latch, ns_latch_nxt;
    logic             ew_latch, ew_latch_nxt;
    logic             toggle, toggle_nxt;
    logic [2:0]       ns_lamp_nxt, ew_lamp_nxt;

    // Next-state and timer logic.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        state_nxt  = state;
        timer_nxt  = timer;
        toggle_nxt = toggle;

        if (flash_en) begin
            // Maintenance mode wins over any phase expiry.
            state_nxt = FLASH;
            if (state != FLASH) begin
                toggle_nxt = 1'b1;
            end else if (tick) begin
                toggle_nxt = ~toggle;
            end
        end else if (state == FLASH) begin
            state_nxt = RED_B;
            timer_nxt = ALLRED_LOAD;
        end else if (tick) begin
            if (timer != '0) begin
                timer_nxt = timer - CNT_W'(1);
            end else begin
                case (state)
                    NS_G: begin
                        // Green is held (timer parked at zero) until the
                        // crossing road has asked for service.
                        if (ew_latch) begin
                            state_nxt = NS_Y;
                            timer_nxt = YELLOW_LOAD;
                        end
                    end
                    NS_Y: begin
                        state_nxt = RED_A;
                        timer_nxt = ALLRED_LOAD;
                    end
                    RED_A: begin
                        state_nxt = EW_G;
                        timer_nxt = GREEN_LOAD;
                    end
                    EW_G: begin
                        if (ns_latch) begin
                            state_nxt = EW_Y;
                            timer_nxt = YELLOW_LOAD;
                        end
                    end
                    EW_Y: begin
                        state_nxt = RED_B;
                        timer_nxt = ALLRED_LOAD;
                    end
                    RED_B: begin
                        state_nxt = NS_G;
                        timer_nxt = GREEN_LOAD;
                    end
                    default: begin
                        // Unused encoding: recover through all-red.
                        state_nxt = RED_B;
                        timer_nxt = ALLRED_LOAD;
                    end
                endcase
            end
        end
    end

    // Each green clears only its own request latch, so two standing requests
    // alternate rather than one starving the other. A request coinciding with
    // the clearing edge is dropped; a held level re-sets it one cycle later.
    always_comb begin
        ns_latch_nxt = ns_latch | ns_req;
        ew_latch_nxt = ew_latch | ew_req;
        if (state_nxt == NS_G && state != NS_G) begin
            ns_latch_nxt = 1'b0;
        end
        if (state_nxt == EW_G && state != EW_G) begin
            ew_latch_nxt = 1'b0;
        end
    end

    // Lamps are decoded from the next state so they flip on the same edge as
    // the state register and come straight out of flops.
    always_comb begin
        ns_lamp_nxt = LAMP_R;
        ew_lamp_nxt = LAMP_R;
        case (state_nxt)
            NS_G:    ns_lamp_nxt = LAMP_G;
            NS_Y:    ns_lamp_nxt = LAMP_Y;
            EW_G:    ew_lamp_nxt = LAMP_G;
            EW_Y:    ew_lamp_nxt = LAMP_Y;
            FLASH: begin
                ns_lamp_nxt = toggle_nxt ? LAMP_Y : LAMP_DARK;
                ew_lamp_nxt = toggle_nxt ? LAMP_Y : LAMP_DARK;
            end
            default: begin
                ns_lamp_nxt = LAMP_R;
                ew_lamp_nxt = LAMP_R;
            end
        endcase
    end

    // NOTE: state uses non-blocking assignments so every flop samples the
    // values from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the asynchronous reset forces the lamps to all-red at
            // once, without waiting for a clock edge.
            state    <= RED_B;
            timer    <= ALLRED_LOAD;
            ns_latch <= 1'b0;
            ew_latch <= 1'b0;
            toggle   <= 1'b0;
            ns_lamp  <= LAMP_R;
            ew_lamp  <= LAMP_R;
        end else begin
            state    <= state_nxt;
            timer    <= timer_nxt;
            ns_latch <= ns_latch_nxt;
            ew_latch <= ew_latch_nxt;
            toggle   <= toggle_nxt;
            ns_lamp  <= ns_lamp_nxt;
            ew_lamp  <= ew_lamp_nxt;
        end
    end

    assign phase = state;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// -----------------------------------------------------------------------------
// tb_traffic_light_ctrl
//
// Self-checking bench for traffic_light_ctrl with GREEN=4, YELLOW=2, ALLRED=1.
// A reference model tracks the phase name and the number of ticks spent in it;
// every clocked step compares the DUT against that model. Directed tables and
// sequences cover the normal cycle, green hold, slow timebase, freeze, flash
// mode and asynchronous reset; a long random run follows.
// -----------------------------------------------------------------------------
module tb_traffic_light_ctrl;

    localparam int G_T = 4;
    localparam int Y_T = 2;
    localparam int A_T = 1;
    localparam int SERVE_BOUND = 2 * (G_T + Y_T + A_T);

    localparam int P_NS_G  = 0;
    localparam int P_NS_Y  = 1;
    localparam int P_RED_A = 2;
    localparam int P_EW_G  = 3;
    localparam int P_EW_Y  = 4;
    localparam int P_RED_B = 5;
    localparam int P_FLASH = 6;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;
    localparam logic [2:0] D = 3'b000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick, ns_req, ew_req, flash_en;
    logic [2:0] ns_lamp, ew_lamp, phase;

    traffic_light_ctrl #(
        .CNT_W       (8),
        .GREEN_TICKS (G_T),
        .YELLOW_TICKS(Y_T),
        .ALLRED_TICKS(A_T)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .tick    (tick),
        .ns_req  (ns_req),
        .ew_req  (ew_req),
        .flash_en(flash_en),
        .ns_lamp (ns_lamp),
        .ew_lamp (ew_lamp),
        .phase   (phase)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_ph;      // phase name (0..6)
    int m_cnt;     // ticks counted since entering the phase
    bit m_nsl, m_ewl, m_tog;

    function automatic int dur(input int ph);
        case (ph)
            P_NS_G, P_EW_G: return G_T;
            P_NS_Y, P_EW_Y: return Y_T;
            default:        return A_T;
        endcase
    endfunction

    function automatic logic [2:0] exp_ns(input int ph, input bit tog);
        case (ph)
            P_NS_G:  return G;
            P_NS_Y:  return Y;
            P_FLASH: return tog ? Y : D;
            default: return R;
        endcase
    endfunction

    function automatic logic [2:0] exp_ew(input int ph, input bit tog);
        case (ph)
            P_EW_G:  return G;
            P_EW_Y:  return Y;
            P_FLASH: return tog ? Y : D;
            default: return R;
        endcase
    endfunction

    task automatic model_reset();
        m_ph = P_RED_B; m_cnt = 0; m_nsl = 0; m_ewl = 0; m_tog = 0;
    endtask

    task automatic model_step();
        int nph;
        bit nsl_n, ewl_n, go;
        nph   = m_ph;
        nsl_n = m_nsl | ns_req;
        ewl_n = m_ewl | ew_req;
        if (flash_en) begin
            if (m_ph != P_FLASH) begin
                nph = P_FLASH; m_tog = 1;
            end else if (tick) begin
                m_tog = !m_tog;
            end
        end else if (m_ph == P_FLASH) begin
            nph = P_RED_B; m_cnt = 0;
        end else if (tick) begin
            m_cnt++;
            if (m_cnt >= dur(m_ph)) begin
                go = 1;
                if (m_ph == P_NS_G) go = m_ewl;
                if (m_ph == P_EW_G) go = m_nsl;
                if (go) begin
                    nph   = (m_ph == P_RED_B) ? P_NS_G : m_ph + 1;
                    m_cnt = 0;
                end
            end
        end
        if (nph == P_NS_G && m_ph != P_NS_G) nsl_n = 0;
        if (nph == P_EW_G && m_ph != P_EW_G) ewl_n = 0;
        m_ph  = nph;
        m_nsl = nsl_n;
        m_ewl = ewl_n;
    endtask

    task automatic compare_model();
        check("phase", phase, m_ph);
        check("ns_lamp", ns_lamp, exp_ns(m_ph, m_tog));
        check("ew_lamp", ew_lamp, exp_ew(m_ph, m_tog));
        if (phase != 3'd6) begin
            check("no_conflict", (ns_lamp != R) && (ew_lamp != R), 0);
            check("onehot", $onehot(ns_lamp) && $onehot(ew_lamp), 1);
        end
    endtask

    // One clock: DUT and model advance on the same edge, outputs sampled 1ns later.
    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        compare_model();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0; tick = 0; ns_req = 0; ew_req = 0; flash_en = 0;
        #2;
        model_reset();
        check("rst_phase", phase, P_RED_B);
        check("rst_ns", ns_lamp, R);
        check("rst_ew", ew_lamp, R);
        @(negedge clk);
        rst_n = 1;
    endtask

    typedef struct {
        bit         tick, ns_req, ew_req, flash_en;
        logic [2:0] ns, ew, ph;
    } vec_t;

    vec_t vt[15];

    function automatic vec_t mk(input bit t, input bit nr, input bit er, input bit fe,
                                input logic [2:0] ns, input logic [2:0] ew, input logic [2:0] ph);
        vec_t v;
        v.tick = t; v.ns_req = nr; v.ew_req = er; v.flash_en = fe;
        v.ns = ns; v.ew = ew; v.ph = ph;
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int last_change, frozen;
        logic [2:0] prev;
        bit ns_pend, ew_pend, t_s, nr_s, er_s;
        int ns_age, ew_age;

        // Normal cycle with ew_req held and one ns_req pulse on cycle 10.
        vt[0]  = mk(1, 0, 1, 0, G, R, 3'd0);
        vt[1]  = mk(1, 0, 1, 0, G, R, 3'd0);
        vt[2]  = mk(1, 0, 1, 0, G, R, 3'd0);
        vt[3]  = mk(1, 0, 1, 0, G, R, 3'd0);
        vt[4]  = mk(1, 0, 1, 0, Y, R, 3'd1);
        vt[5]  = mk(1, 0, 1, 0, Y, R, 3'd1);
        vt[6]  = mk(1, 0, 1, 0, R, R, 3'd2);
        vt[7]  = mk(1, 0, 1, 0, R, G, 3'd3);
        vt[8]  = mk(1, 0, 1, 0, R, G, 3'd3);
        vt[9]  = mk(1, 1, 1, 0, R, G, 3'd3);
        vt[10] = mk(1, 0, 1, 0, R, G, 3'd3);
        vt[11] = mk(1, 0, 1, 0, R, Y, 3'd4);
        vt[12] = mk(1, 0, 1, 0, R, Y, 3'd4);
        vt[13] = mk(1, 0, 1, 0, R, R, 3'd5);
        vt[14] = mk(1, 0, 1, 0, G, R, 3'd0);

        do_reset();
        for (int i = 0; i < 15; i++) begin
            tick = vt[i].tick; ns_req = vt[i].ns_req;
            ew_req = vt[i].ew_req; flash_en = vt[i].flash_en;
            step();
            check($sformatf("vec%0d_phase", i), phase, vt[i].ph);
            check($sformatf("vec%0d_ns", i), ns_lamp, vt[i].ns);
            check($sformatf("vec%0d_ew", i), ew_lamp, vt[i].ew);
            @(negedge clk);
        end

        // Green hold with no demand, then a single-cycle ew_req on cycle 20.
        do_reset();
        tick = 1;
        for (int c = 1; c <= 19; c++) step();
        check("hold_ns_g", phase, P_NS_G);
        @(negedge clk); ew_req = 1;
        step();
        check("hold_c20", phase, P_NS_G);
        @(negedge clk); ew_req = 0;
        step(); check("hold_c21_ns_y", phase, P_NS_Y);
        step(); check("hold_c22_ns_y", phase, P_NS_Y);
        step(); check("hold_c23_red_a", phase, P_RED_A);
        step(); check("hold_c24_ew_g", phase, P_EW_G);

        // Tick every 4th cycle: each phase lasts 4*DUR cycles.
        do_reset();
        ew_req = 1;
        last_change = -1;
        prev = phase;
        for (int c = 1; c <= 120; c++) begin
            @(negedge clk);
            tick = (c % 4 == 0);
            step();
            if (phase != prev) begin
                if (last_change >= 0 && prev <= 3'd2)
                    check($sformatf("slow_dur_ph%0d", prev), c - last_change, 4 * dur(prev));
                last_change = c;
                prev = phase;
            end
        end

        // Timebase stalled: nothing moves even with both requests up.
        frozen = m_ph;
        @(negedge clk);
        tick = 0; ns_req = 1; ew_req = 1;
        for (int c = 0; c < 50; c++) step();
        check("freeze_phase", phase, frozen);
        check("freeze_ew", ew_lamp, exp_ew(frozen, 0));

        // Flash entry from EW_G, toggling, exit through RED_B.
        check("pre_flash", phase, P_EW_G);
        @(negedge clk);
        ns_req = 0; ew_req = 0; tick = 1; flash_en = 1;
        step(); check("fl_enter_ph", phase, P_FLASH); check("fl_enter_ns", ns_lamp, Y); check("fl_enter_ew", ew_lamp, Y);
        step(); check("fl_dark_ns", ns_lamp, D); check("fl_dark_ew", ew_lamp, D);
        step(); check("fl_on_ns", ns_lamp, Y);
        @(negedge clk); tick = 0;
        step(); check("fl_hold_ns", ns_lamp, Y);
        @(negedge clk); flash_en = 0;
        step(); check("fl_exit_ph", phase, P_RED_B); check("fl_exit_ns", ns_lamp, R); check("fl_exit_ew", ew_lamp, R);
        @(negedge clk); tick = 1;
        step(); check("fl_after_ns_g", phase, P_NS_G);

        // Asynchronous reset in the middle of NS_Y.
        do_reset();
        tick = 1; ew_req = 1;
        for (int c = 0; c < 20 && m_ph != P_NS_Y; c++) step();
        check("reach_ns_y", phase, P_NS_Y);
        @(negedge clk);
        #2 rst_n = 0;
        #1;
        check("arst_ns", ns_lamp, R);
        check("arst_ew", ew_lamp, R);
        check("arst_phase", phase, P_RED_B);
        model_reset();
        @(negedge clk); rst_n = 1;
        step(); check("arst_restart_ns_g", phase, P_NS_G);
        for (int c = 0; c < 14; c++) step();

        // Random run without flash: model compare plus service latency.
        do_reset();
        ns_pend = 0; ew_pend = 0; ns_age = 0; ew_age = 0;
        for (int c = 0; c < 5000; c++) begin
            tick   = ($urandom_range(0, 1) == 1);
            ns_req = ($urandom_range(0, 7) == 0);
            ew_req = ($urandom_range(0, 7) == 0);
            t_s = tick; nr_s = ns_req; er_s = ew_req;
            step();
            if (ew_lamp == G) begin
                if (ew_pend) check("ew_latency_ok", ew_age <= SERVE_BOUND, 1);
                ew_pend = 0;
            end else begin
                if (ew_pend && t_s) ew_age++;
                if (!ew_pend && er_s) begin ew_pend = 1; ew_age = 0; end
            end
            if (ns_lamp == G) begin
                if (ns_pend) check("ns_latency_ok", ns_age <= SERVE_BOUND, 1);
                ns_pend = 0;
            end else begin
                if (ns_pend && t_s) ns_age++;
                if (!ns_pend && nr_s) begin ns_pend = 1; ns_age = 0; end
            end
            @(negedge clk);
        end

        // Random run with maintenance mode switching in and out.
        for (int c = 0; c < 5000; c++) begin
            tick   = ($urandom_range(0, 1) == 1);
            ns_req = ($urandom_range(0, 5) == 0);
            ew_req = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 31) == 0) flash_en = !flash_en;
            step();
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
